// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus shared by the boot loader
// and whatever feeds it (UART receiver) and consumes it (instruction RAM).
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  // Environment side: supplies the byte stream and observes memory writes.
  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  // Loader side: consumes the byte stream and produces memory writes.
  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a framed image (LEN_LO, LEN_HI, payload, CSUM) from a
// byte stream, packs payload bytes little-endian into 32-bit words, writes
// them to instruction memory and holds the core in reset until a clean load.
module imem_loader #(
  parameter int MEM_BYTES = 1600,
  parameter int TIMEOUT   = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
  localparam logic [31:0] IDLE_MAX  = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  sum_q, sum_d;
  logic [23:0] word_q, word_d;
  logic [31:0] idle_q, idle_d;
  logic [1:0]  err_q, err_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        active;
  logic        accept;
  logic [15:0] len_full;
  logic        len_bad;
  logic        timeout_hit;

  // Handshake, length validation and timeout detection derived from the current state.
  always_comb begin
    active      = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
    accept      = bus.rx_valid && active;
    len_full    = {bus.rx_data, len_q[7:0]};
    len_bad     = (len_full == 16'd0) || (len_full[1:0] != 2'b00) ||
                  (32'(len_full) > MEM_LIMIT);
    timeout_hit = (TIMEOUT != 0) && active && !accept &&
                  ((idle_q + 32'd1) == IDLE_MAX);
  end

  // Next-state logic: frame parsing, word assembly, write generation and error capture.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    word_d    = word_q;
    idle_d    = idle_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (active) begin
      idle_d = accept ? 32'd0 : idle_q + 32'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN0;
          err_d   = 2'b00;
          len_d   = 16'd0;
          count_d = 16'd0;
          addr_d  = 32'd0;
          sum_d   = 8'd0;
          word_d  = 24'd0;
          idle_d  = 32'd0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d[15:8] = bus.rx_data;
          if (len_bad) begin
            state_d = S_ERR;
            err_d   = 2'b01;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d   = sum_q + bus.rx_data;
          count_d = count_q + 16'd1;
          unique case (count_q[1:0])
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = {bus.rx_data, word_q};
              addr_d    = addr_q + 32'd4;
            end
          endcase
          if ((count_q + 16'd1) == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.rx_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 2'b10;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      state_d = S_ERR;
      err_d   = 2'b11;
    end
  end

  // State and datapath registers; reset drops any partially assembled word or pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      count_q   <= 16'd0;
      addr_q    <= 32'd0;
      sum_q     <= 8'd0;
      word_q    <= 24'd0;
      idle_q    <= 32'd0;
      err_q     <= 2'b00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 32'd0;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      word_q    <= word_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Outputs: ready and status follow the state register directly.
  always_comb begin
    bus.rx_ready = active;
    bus.wr_en    = wr_en_q;
    bus.wr_addr  = wr_addr_q;
    bus.wr_data  = wr_data_q;
    busy         = active;
    done         = (state_q == S_DONE);
    cpu_hold     = (state_q != S_DONE);
    err_code     = err_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random and directed framed images, a queue of
// expected memory writes drained by an independent write monitor, and
// status checks derived from a frame-level reference model.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  imem_loader_if bus ();

  imem_loader #(.MEM_BYTES(1600), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err_code (err_code)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int     total = 0;
  int     bad   = 0;
  wr_t    exp_q[$];
  bit     spacing_on = 1'b0;
  longint cycle      = 0;
  longint last_wr    = -1;

  // Free-running cycle count used to measure write spacing.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                   bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", bus.wr_addr, e.addr);
          checkOutput("wr_data", bus.wr_data, e.data);
        end
        if (spacing_on) begin
          if (last_wr >= 0) checkOutput("wr_spacing", 32'(cycle - last_wr), 32'd4);
          last_wr = cycle;
        end
      end
    end
  end

  // Present one byte after 'gap' idle cycles and wait until it is accepted.
  task automatic sendByte(input logic [7:0] b, input int gap, input bit pulse_start);
    int waits;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    start        = pulse_start;
    waits = 0;
    while (bus.rx_ready !== 1'b1 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (bus.rx_ready !== 1'b1) checkOutput("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Pulse start while already presenting the first byte: IDLE must not take it.
  task automatic startPulse(input logic [7:0] first_byte);
    checkOutput("rx_ready_before_start", 32'(bus.rx_ready), 32'd0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = first_byte;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("cpu_hold_loading", 32'(cpu_hold), 32'd1);
    checkOutput("done_cleared", 32'(done), 32'd0);
    checkOutput("err_cleared", 32'(err_code), 32'd0);
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (busy !== 1'b0) checkOutput("busy_release", 32'(busy), 32'd0);
  endtask

  // Run one complete frame; the reference model predicts writes and final status.
  task automatic applyStimulus(input logic [15:0] len, input logic [7:0] payload[$],
                               input logic [7:0] csum, input int max_gap, input int start_at);
    bit         len_bad;
    logic [7:0] sum;
    logic [1:0] exp_err;
    int         cycles;
    len_bad = (len == 0) || (len % 4 != 0) || (len > 1600);
    sum = 8'd0;
    if (!len_bad) begin
      for (int i = 0; i < int'(len); i++) sum = 8'((int'(sum) + int'(payload[i])) % 256);
      for (int w = 0; w < int'(len) / 4; w++)
        exp_q.push_back('{addr: 32'(4 * w),
                          data: 32'(payload[4*w]) + (32'(payload[4*w+1]) << 8) +
                                (32'(payload[4*w+2]) << 16) + (32'(payload[4*w+3]) << 24)});
    end
    exp_err = len_bad ? 2'b01 : ((csum == sum) ? 2'b00 : 2'b10);

    startPulse(len[7:0]);
    sendByte(len[7:0], 0, 1'b0);
    sendByte(len[15:8], $urandom_range(0, max_gap), 1'b0);
    if (!len_bad) begin
      for (int i = 0; i < int'(len); i++)
        sendByte(payload[i], $urandom_range(0, max_gap), i == start_at);
      sendByte(csum, $urandom_range(0, max_gap), 1'b0);
    end
    bus.rx_valid = 1'b0;
    waitIdle(cycles);
    @(negedge clk);
    checkOutput("done", 32'(done), (exp_err == 2'b00) ? 32'd1 : 32'd0);
    checkOutput("err_code", 32'(err_code), 32'(exp_err));
    checkOutput("cpu_hold", 32'(cpu_hold), (exp_err == 2'b00) ? 32'd0 : 32'd1);
    checkOutput("rx_ready_after", 32'(bus.rx_ready), 32'd0);
    checkOutput("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  logic [7:0] good_img[$] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

  // Directed test-plan scenarios followed by random frames.
  initial begin
    logic [7:0] pl[$];
    logic [7:0] s;
    logic [15:0] rlen;
    int cycles;

    rst_n        = 1'b0;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_wr_addr", bus.wr_addr, 32'd0);
    checkOutput("rst_wr_data", bus.wr_data, 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] good image");
    applyStimulus(16'd8, good_img, 8'hC0, 0, -1);

    $display("[TB] bad lengths");
    pl.delete();
    applyStimulus(16'h0006, pl, 8'h00, 0, -1);
    applyStimulus(16'h0644, pl, 8'h00, 0, -1);
    applyStimulus(16'h0000, pl, 8'h00, 0, -1);

    $display("[TB] checksum error then recovery");
    applyStimulus(16'd8, good_img, 8'hC1, 1, -1);
    applyStimulus(16'd8, good_img, 8'hC0, 2, -1);

    $display("[TB] timeout");
    startPulse(8'h08);
    sendByte(8'h08, 0, 1'b0);
    sendByte(8'h00, 0, 1'b0);
    sendByte(8'h13, 0, 1'b0);
    sendByte(8'h05, 0, 1'b0);
    sendByte(8'h00, 0, 1'b0);
    bus.rx_valid = 1'b0;
    waitIdle(cycles);
    checkOutput("timeout_latency", 32'(cycles), 32'd16);
    checkOutput("timeout_err", 32'(err_code), 32'd3);
    checkOutput("timeout_done", 32'(done), 32'd0);
    checkOutput("timeout_hold", 32'(cpu_hold), 32'd1);

    $display("[TB] reset mid-load");
    exp_q.push_back('{addr: 32'd0, data: 32'h00000513});
    startPulse(8'h08);
    sendByte(8'h08, 0, 1'b0);
    sendByte(8'h00, 0, 1'b0);
    for (int i = 0; i < 6; i++) sendByte(good_img[i], 0, 1'b0);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    checkOutput("midrst_rx_ready", 32'(bus.rx_ready), 32'd0);
    checkOutput("midrst_wr_addr", bus.wr_addr, 32'd0);
    checkOutput("midrst_wr_data", bus.wr_data, 32'd0);
    checkOutput("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'd8, good_img, 8'hC0, 0, -1);

    $display("[TB] full-size back-to-back image");
    pl.delete();
    s = 8'd0;
    for (int i = 0; i < 1600; i++) pl.push_back(8'($urandom));
    foreach (pl[i]) s = s + pl[i];
    last_wr    = -1;
    spacing_on = 1'b1;
    applyStimulus(16'd1600, pl, s, 0, 800);
    spacing_on = 1'b0;

    $display("[TB] random frames");
    for (int f = 0; f < 10; f++) begin
      pl.delete();
      rlen = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 1700))
                                         : 16'(4 * $urandom_range(1, 24));
      s = 8'd0;
      if (rlen != 0 && rlen % 4 == 0 && rlen <= 1600)
        for (int i = 0; i < int'(rlen); i++) begin
          pl.push_back(8'($urandom));
          s = s + pl[i];
        end
      if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      applyStimulus(rlen, pl, s, 3, -1);
    end

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that fills instruction memory from a byte stream (typically UART RX) before the core runs. It parses a framed image (length, payload, checksum) and packs payload bytes little-endian into 32-bit words. It issues one word write per 4 bytes, so the byte at address A lands in bits [7:0] of the fetched word at A. It holds the CPU in reset until an image loads cleanly.

## Interface
- MEM_BYTES, 1600: instruction memory size in bytes; upper bound on image length.
- TIMEOUT, 1000000: idle cycles allowed between accepted bytes while loading; 0 disables the timeout.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  one-cycle instruction-memory word write strobe.
- wr_addr  out  32  byte address of the word, always a multiple of 4.
- wr_data  out  32  {b3,b2,b1,b0}, where b0 is the first-received byte.
- cpu_hold  out  1  holds the core in reset.
- busy  out  1  a load is in progress.
- done  out  1  last load succeeded; sticky.
- err_code  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout; sticky.

## Operation
- **Frame format:** LEN_LO, LEN_HI (16-bit byte count, little-endian), then LEN payload bytes, then CSUM, where CSUM = sum of payload bytes mod 256.
- **Byte acceptance:** a byte is accepted on a rising edge where rx_valid && rx_ready.
- **States:** IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- **IDLE/DONE/ERR + start:**
  - Go to LEN0.
  - Clear done and err_code.
  - Set cpu_hold=1, busy=1.
  - Reset the byte counter, word address (0) and running sum (0).
- **LEN0:** accept a byte into len[7:0], then go to LEN1.
- **LEN1:** accept a byte into len[15:8], then:
  - if len==0, len[1:0]!=0, or len>MEM_BYTES: go to ERR with code 01;
  - otherwise go to DATA.
- **DATA:**
  - Each accepted byte goes into the shift lane selected by count[1:0] and is added to the 8-bit sum.
  - On the 4th byte of a word, register a write: wr_en=1 next cycle, with wr_addr = current word address and wr_data = the assembled word. The word address then advances by 4.
  - After byte number len is accepted, go to CSUM.
- **CSUM:** accept one byte.
  - If it equals the sum: go to DONE, set done=1, clear cpu_hold.
  - Otherwise: go to ERR with code 10.
- **ERR:** busy=0, cpu_hold stays 1. Memory already written is not rolled back.
- **DONE:** busy=0, cpu_hold=0.
- **start while busy:** ignored.
- **Timeout:**
  - An idle counter runs in LEN0..CSUM and clears on every accepted byte.
  - When it reaches TIMEOUT (and TIMEOUT≠0), go to ERR with code 11.
  - A partial word is discarded.
- **Width rules:**
  - The byte counter is 16 bits; the sum is 8 bits and wraps.
  - wr_addr upper bits are zero. wr_addr never reaches or exceeds MEM_BYTES, guaranteed by the length check.

## Timing
- **Reset values:** rx_ready 0, wr_en 0, wr_addr 0, wr_data 0, cpu_hold 1, busy 0, done 0, err_code 00, state IDLE.
- **Reset mid-load:** returns immediately to IDLE with the reset values above. Any write not yet strobed is dropped.
- **rx_ready:** a combinational function of state only. It is 1 in LEN0, LEN1, DATA and CSUM, and 0 elsewhere. The loader never stalls the stream, so one byte per cycle is sustained.
- **Write latency:** wr_en pulses exactly one cycle, in the cycle after the 4th byte of a word is accepted. It is never asserted twice in consecutive cycles at 1 byte/cycle except for back-to-back words, which produce one pulse every 4 cycles. The memory must accept a write on every pulse.
- **State latency:** start → LEN0 on the next edge. The final CSUM byte → DONE/ERR on the same edge. done, err_code and cpu_hold update with the state register.
- **Last write vs. CSUM:** the last word's wr_en coincides with the first CSUM cycle, and both are handled.
- **start coincident with a byte in IDLE:** the byte is not accepted (rx_ready=0).

## Test plan
- **Good image:** start, then 08 00 13 05 00 00 93 05 10 00 C0 → wr (0, 0x00000513), then wr (4, 0x00100593); done=1, err_code=00, cpu_hold 1→0, busy=0.
- **Bad length:** start, then 06 00 → ERR with err_code=01, no wr_en. Repeat with 44 06 (1604 > 1600) → err_code=01.
- **Checksum error:** same frame as the good image but CSUM=C1 → two writes occur, err_code=10, done=0, cpu_hold=1. A following start plus the good frame → done=1, err_code=00.
- **Timeout:** TIMEOUT=16; start, 08 00 13 05 00, then rx_valid=0 → ERR with err_code=11 exactly 16 cycles after the last accept, no wr_en.
- **Reset mid-load:** assert rst_n=0 after 6 payload bytes → all outputs at reset values, cpu_hold=1. After release, a full good frame loads correctly starting at address 0.
- **Busy/back-to-back:** start pulsed in DATA is ignored. A 1600-byte image at 1 byte/cycle → 400 writes at addresses 0..1596 step 4, one every 4 cycles; done=1.
